axis_pixel_proc: RTL and testbench
==================================

# axis_pixel_proc

Parametrised AXI4-Stream pixel processor for the DDR image path. It sits between the DMA MM2S and S2MM streams and applies one of four per-pixel operations to every lane of a multi-pixel beat: pass, invert, threshold or saturating offset. The datapath is fully registered behind a skid buffer so both stream interfaces are timing-clean. Configuration is latched once per frame, so a mode change never tears an image.

## Interface
Parameters:
- `PIX_W`, 8: pixel width in bits; legal values 8 or 16.
- `NPIX`, 1: pixels per beat; any value from 1 to 8.
- `CNT_W`, 16: width of the frame counter.
- Derived, not overridable: `DATA_W = PIX_W*NPIX` and `KEEP_W = DATA_W/8`.

Ports:
- `aclk`  in  1: the only clock.
- `aresetn`  in  1: asynchronous, active-low reset.
- `cfg_mode`  in  2: requested operation; 0 pass, 1 invert, 2 threshold, 3 offset.
- `cfg_thr`  in  PIX_W: threshold level, used in mode 2.
- `cfg_offset`  in  PIX_W+1: signed two's-complement offset, used in mode 3.
- `s_axis_tdata`  in  DATA_W: input pixels; lane i is bits [i*PIX_W +: PIX_W].
- `s_axis_tkeep`  in  KEEP_W: input byte enables.
- `s_axis_tvalid`  in  1: input beat valid.
- `s_axis_tlast`  in  1: last beat of a frame.
- `s_axis_tready`  out  1: block can accept an input beat.
- `m_axis_tdata`  out  DATA_W: processed pixels.
- `m_axis_tkeep`  out  KEEP_W: output byte enables.
- `m_axis_tvalid`  out  1: output beat valid.
- `m_axis_tlast`  out  1: last beat of a frame.
- `m_axis_tready`  in  1: downstream can accept a beat.
- `frame_cnt`  out  CNT_W: number of frames fully emitted.

## Operation
- Lane operation, with MAX = 2^PIX_W − 1 and p the input pixel:
  - Mode 0: output p.
  - Mode 1: output MAX − p.
  - Mode 2: output MAX if p ≥ `cfg_thr`, otherwise 0.
  - Mode 3: output p + `cfg_offset`, computed in PIX_W+2 bits and clamped to the range [0, MAX].
- Keep handling:
  - A lane whose keep bits are all 0 outputs data 0.
  - `tkeep` and `tlast` pass through unchanged alongside their beat.
- Frame-boundary configuration:
  - Internal flag `sof` is set by reset and by every accepted input beat with tlast=1. It is cleared by every accepted beat with tlast=0.
  - When a beat is accepted with `sof`=1, that beat uses the live `cfg_*` values, and those values are captured into shadow registers.
  - All other beats use the shadow registers.
  - `cfg_*` changes made mid-frame take effect at the next frame.
- Frame counter:
  - `frame_cnt` increments when `m_axis_tvalid & m_axis_tready & m_axis_tlast`.
  - It wraps from 2^CNT_W − 1 to 0.
- Output stage is a two-entry buffer: one main register plus one skid register.
  - States: EMPTY, ONE, FULL.
  - EMPTY → ONE: input beat accepted.
  - ONE stays ONE: accept and emit in the same cycle, or neither happens.
  - ONE → FULL: input accepted while `m_axis_tready`=0.
  - ONE → EMPTY: beat emitted with no input accepted.
  - FULL → ONE: beat emitted; the skid entry moves to the main register.
  - `s_axis_tready` = 1 exactly when the state is not FULL. It is a registered signal.

## Timing
- Reset values while `aresetn`=0, applied asynchronously:
  - `m_axis_tvalid`, `m_axis_tdata`, `m_axis_tkeep`, `m_axis_tlast`: 0.
  - `s_axis_tready`: 0.
  - `frame_cnt`: 0.
  - State: EMPTY; `sof`: 1; shadow registers: 0.
- `s_axis_tready` rises on the first `aclk` edge after reset is released.
- Reset asserted mid-frame discards any buffered beats. The next accepted beat is treated as a start of frame.
- Latency: a beat accepted at edge k is presented on `m_axis_*` after edge k, i.e. in cycle k+1.
- Throughput is 1 beat per cycle while `m_axis_tready`=1.
- If `m_axis_tready` drops, at most one further beat is accepted, into the skid register. `s_axis_tready` is low from the following cycle.
- When input accept and output emit happen in the same cycle, both complete; no bubble is inserted.
- `m_axis_*` outputs hold stable while `m_axis_tvalid`=1 and `m_axis_tready`=0.

## Structure
- Package `axis_pixel_pkg` holds:
  - Mode localparams: `MODE_PASS`, `MODE_INV`, `MODE_THR`, `MODE_OFS`.
  - Buffer state encoding.
- Sub-module `axis_skid_buf`, parametrised on payload width. It holds the EMPTY/ONE/FULL handshake logic; its payload is `{tlast, tkeep, tdata}`.
- The top level holds:
  - Per-lane combinational processing, generated over `NPIX` lanes.
  - The `sof` flag and shadow configuration registers.
  - The frame counter.

## Test plan
- Invert: PIX_W=8, NPIX=4, mode 1, input 0x00_7F_80_FF, keep 0xF → output 0xFF_80_7F_00 exactly one cycle after accept.
- Offset saturation: mode 3.
  - Offset +20 with pixels 250 and 10 → outputs 255 and 30.
  - Offset −20 with pixel 5 → output 0.
- Threshold: mode 2, thr 0x80; inputs 0x7F and 0x80 → outputs 0x00 and 0xFF.
- Mid-frame config change: switch `cfg_mode` from 1 to 0 at beat 3 of a 5-beat frame → beats 3–5 remain inverted; the next frame passes through unchanged; `frame_cnt` reads 1 then 2.
- Backpressure: continuous valid input, `m_axis_tready` low for 4 cycles → exactly one extra beat accepted; no beat lost or duplicated; outputs held stable; 1 beat/cycle resumes afterwards.
- Reset mid-frame and partial keep: assert `aresetn` low while FULL → all outputs 0 immediately; the next frame uses the new cfg on its first beat. Keep 0b0011 with NPIX=4 → upper two lanes output 0.

Source files
------------

// File: rtl/axis_pixel_pkg.sv
// Shared definitions for the AXI4-Stream pixel processor: lane operation codes
// and the output buffer state encoding.
package axis_pixel_pkg;

  localparam logic [1:0] MODE_PASS = 2'd0;
  localparam logic [1:0] MODE_INV  = 2'd1;
  localparam logic [1:0] MODE_THR  = 2'd2;
  localparam logic [1:0] MODE_OFS  = 2'd3;

  typedef enum logic [1:0] {
    BUF_EMPTY = 2'd0,
    BUF_ONE   = 2'd1,
    BUF_FULL  = 2'd2
  } buf_state_e;

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry registered stream buffer (main + skid) with a registered upstream ready,
// so neither handshake direction has a combinational path through the block.
module axis_skid_buf
  import axis_pixel_pkg::*;
#(
  parameter int unsigned W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         s_valid_i,
  input  logic [W-1:0] s_data_i,
  output logic         s_ready_o,
  output logic         m_valid_o,
  output logic [W-1:0] m_data_o,
  input  logic         m_ready_i
);

  buf_state_e   state_q, state_d;
  logic [W-1:0] main_q, main_d;
  logic [W-1:0] skid_q, skid_d;
  logic         ready_q, ready_d;
  logic         accept;
  logic         emit;

  assign accept    = s_valid_i & ready_q;
  assign m_valid_o = (state_q != BUF_EMPTY);
  assign emit      = m_valid_o & m_ready_i;
  assign s_ready_o = ready_q;
  assign m_data_o  = main_q;

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    unique case (state_q)
      BUF_EMPTY: begin
        if (accept) begin
          main_d  = s_data_i;
          state_d = BUF_ONE;
        end
      end
      BUF_ONE: begin
        if (accept && emit) begin
          main_d = s_data_i;
        end else if (accept) begin
          skid_d  = s_data_i;
          state_d = BUF_FULL;
        end else if (emit) begin
          state_d = BUF_EMPTY;
        end
      end
      BUF_FULL: begin
        if (emit) begin
          main_d  = skid_q;
          state_d = BUF_ONE;
        end
      end
      default: state_d = BUF_EMPTY;
    endcase
    // Ready is registered from the next state; it is held low during reset and
    // rises on the first edge after release.
    ready_d = (state_d != BUF_FULL);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= BUF_EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
      ready_q <= ready_d;
    end
  end

endmodule

// File: rtl/axis_pixel_proc.sv
// Per-lane pixel operation (pass/invert/threshold/saturating offset) on an AXI4-Stream,
// with configuration latched at start of frame and a frame-completion counter.
module axis_pixel_proc
  import axis_pixel_pkg::*;
#(
  parameter int unsigned PIX_W = 8,
  parameter int unsigned NPIX  = 1,
  parameter int unsigned CNT_W = 16
) (
  input  logic                    aclk,
  input  logic                    aresetn,
  input  logic [1:0]              cfg_mode,
  input  logic [PIX_W-1:0]        cfg_thr,
  input  logic [PIX_W:0]          cfg_offset,
  input  logic [PIX_W*NPIX-1:0]   s_axis_tdata,
  input  logic [PIX_W*NPIX/8-1:0] s_axis_tkeep,
  input  logic                    s_axis_tvalid,
  input  logic                    s_axis_tlast,
  output logic                    s_axis_tready,
  output logic [PIX_W*NPIX-1:0]   m_axis_tdata,
  output logic [PIX_W*NPIX/8-1:0] m_axis_tkeep,
  output logic                    m_axis_tvalid,
  output logic                    m_axis_tlast,
  input  logic                    m_axis_tready,
  output logic [CNT_W-1:0]        frame_cnt
);

  localparam int unsigned DATA_W = PIX_W * NPIX;
  localparam int unsigned KEEP_W = DATA_W / 8;
  localparam int unsigned LKEEP  = PIX_W / 8;
  localparam int unsigned PAY_W  = DATA_W + KEEP_W + 1;

  logic             sof_q, sof_d;
  logic [1:0]       mode_sh_q, mode_sh_d;
  logic [PIX_W-1:0] thr_sh_q, thr_sh_d;
  logic [PIX_W:0]   ofs_sh_q, ofs_sh_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;

  logic             accept;
  logic [1:0]       mode_eff;
  logic [PIX_W-1:0] thr_eff;
  logic [PIX_W:0]   ofs_eff;
  logic [DATA_W-1:0] proc_data;
  logic [PAY_W-1:0]  pay_in;
  logic [PAY_W-1:0]  pay_out;

  assign accept = s_axis_tvalid & s_axis_tready;

  // The first beat of a frame uses the live config; the rest of the frame uses the copy
  // latched on that beat.
  assign mode_eff = sof_q ? cfg_mode   : mode_sh_q;
  assign thr_eff  = sof_q ? cfg_thr    : thr_sh_q;
  assign ofs_eff  = sof_q ? cfg_offset : ofs_sh_q;

  for (genvar i = 0; i < NPIX; i++) begin : g_lane
    logic [PIX_W-1:0] pix;
    logic [PIX_W+1:0] sum;
    logic [PIX_W-1:0] res;

    assign pix = s_axis_tdata[i*PIX_W +: PIX_W];
    assign sum = {2'b00, pix} + {ofs_eff[PIX_W], ofs_eff};

    always_comb begin
      res = pix;
      unique case (mode_eff)
        MODE_PASS: res = pix;
        MODE_INV:  res = ~pix;
        MODE_THR:  res = (pix >= thr_eff) ? '1 : '0;
        MODE_OFS: begin
          if (sum[PIX_W+1])      res = '0;
          else if (sum[PIX_W])   res = '1;
          else                   res = sum[PIX_W-1:0];
        end
      endcase
      if (s_axis_tkeep[i*LKEEP +: LKEEP] == '0) res = '0;
    end

    assign proc_data[i*PIX_W +: PIX_W] = res;
  end

  assign pay_in = {s_axis_tlast, s_axis_tkeep, proc_data};

  axis_skid_buf #(
    .W (PAY_W)
  ) u_buf (
    .clk_i     (aclk),
    .rst_ni    (aresetn),
    .s_valid_i (s_axis_tvalid),
    .s_data_i  (pay_in),
    .s_ready_o (s_axis_tready),
    .m_valid_o (m_axis_tvalid),
    .m_data_o  (pay_out),
    .m_ready_i (m_axis_tready)
  );

  assign m_axis_tlast = pay_out[PAY_W-1];
  assign m_axis_tkeep = pay_out[DATA_W +: KEEP_W];
  assign m_axis_tdata = pay_out[DATA_W-1:0];
  assign frame_cnt    = frame_cnt_q;

  always_comb begin
    sof_d       = sof_q;
    mode_sh_d   = mode_sh_q;
    thr_sh_d    = thr_sh_q;
    ofs_sh_d    = ofs_sh_q;
    frame_cnt_d = frame_cnt_q;
    if (accept) begin
      sof_d = s_axis_tlast;
      if (sof_q) begin
        mode_sh_d = cfg_mode;
        thr_sh_d  = cfg_thr;
        ofs_sh_d  = cfg_offset;
      end
    end
    if (m_axis_tvalid && m_axis_tready && m_axis_tlast) begin
      frame_cnt_d = frame_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sof_q       <= 1'b1;
      mode_sh_q   <= '0;
      thr_sh_q    <= '0;
      ofs_sh_q    <= '0;
      frame_cnt_q <= '0;
    end else begin
      sof_q       <= sof_d;
      mode_sh_q   <= mode_sh_d;
      thr_sh_q    <= thr_sh_d;
      ofs_sh_q    <= ofs_sh_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

// File: tb/tb_axis_pixel_proc.sv
// Directed self-checking bench for axis_pixel_proc with 4 x 8-bit lanes and a 3-bit
// frame counter.
module tb_axis_pixel_proc;

  localparam int unsigned PIX_W  = 8;
  localparam int unsigned NPIX   = 4;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned DATA_W = PIX_W * NPIX;
  localparam int unsigned KEEP_W = DATA_W / 8;

  logic              aclk = 1'b0;
  logic              aresetn;
  logic [1:0]        cfg_mode;
  logic [PIX_W-1:0]  cfg_thr;
  logic [PIX_W:0]    cfg_offset;
  logic [DATA_W-1:0] s_axis_tdata;
  logic [KEEP_W-1:0] s_axis_tkeep;
  logic              s_axis_tvalid;
  logic              s_axis_tlast;
  logic              s_axis_tready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic [KEEP_W-1:0] m_axis_tkeep;
  logic              m_axis_tvalid;
  logic              m_axis_tlast;
  logic              m_axis_tready;
  logic [CNT_W-1:0]  frame_cnt;

  int checks   = 0;
  int failures = 0;

  int          nb_n;
  int          stall_acc;
  int          resume_acc;
  int          emitted;
  logic        acc;
  logic        emi;
  logic [31:0] held;
  logic [31:0] exp_word;
  logic [31:0] q[$];

  always #5 aclk = ~aclk;

  axis_pixel_proc #(
    .PIX_W (PIX_W),
    .NPIX  (NPIX),
    .CNT_W (CNT_W)
  ) dut (
    .aclk          (aclk),
    .aresetn       (aresetn),
    .cfg_mode      (cfg_mode),
    .cfg_thr       (cfg_thr),
    .cfg_offset    (cfg_offset),
    .s_axis_tdata  (s_axis_tdata),
    .s_axis_tkeep  (s_axis_tkeep),
    .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tlast  (s_axis_tlast),
    .s_axis_tready (s_axis_tready),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tready (m_axis_tready),
    .frame_cnt     (frame_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Presents one beat for exactly one edge; the caller guarantees tready is high.
  task automatic beat(input logic [31:0] d, input logic [3:0] k, input logic l);
    chk("s_tready_before_beat", 32'(s_axis_tready), 32'd1);
    s_axis_tdata  = d;
    s_axis_tkeep  = k;
    s_axis_tlast  = l;
    s_axis_tvalid = 1'b1;
    tick();
    s_axis_tvalid = 1'b0;
  endtask

  task automatic expect_out(input string tag, input logic [31:0] d, input logic [3:0] k,
                            input logic l);
    chk({tag, "_valid"}, 32'(m_axis_tvalid), 32'd1);
    chk({tag, "_data"},  m_axis_tdata, d);
    chk({tag, "_keep"},  32'(m_axis_tkeep), 32'(k));
    chk({tag, "_last"},  32'(m_axis_tlast), 32'(l));
  endtask

  task automatic idle_frame_check(input string tag, input logic [2:0] exp_cnt);
    s_axis_tvalid = 1'b0;
    tick();
    chk({tag, "_frame_cnt"}, 32'(frame_cnt), 32'(exp_cnt));
    chk({tag, "_drained"},   32'(m_axis_tvalid), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    aresetn       = 1'b0;
    cfg_mode      = 2'd0;
    cfg_thr       = 8'h00;
    cfg_offset    = 9'h000;
    s_axis_tdata  = '0;
    s_axis_tkeep  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    m_axis_tready = 1'b1;

    // Reset state
    tick();
    tick();
    chk("rst_m_tvalid",  32'(m_axis_tvalid), 32'd0);
    chk("rst_m_tdata",   m_axis_tdata, 32'h0);
    chk("rst_m_tkeep",   32'(m_axis_tkeep), 32'd0);
    chk("rst_m_tlast",   32'(m_axis_tlast), 32'd0);
    chk("rst_s_tready",  32'(s_axis_tready), 32'd0);
    chk("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    aresetn = 1'b1;
    #1;
    chk("release_s_tready_low", 32'(s_axis_tready), 32'd0);
    tick();
    chk("release_s_tready_high", 32'(s_axis_tready), 32'd1);

    // Invert, one cycle latency
    cfg_mode = 2'd1;
    beat(32'h007F80FF, 4'hF, 1'b1);
    expect_out("inv", 32'hFF807F00, 4'hF, 1'b1);
    idle_frame_check("inv", 3'd1);

    // Saturating offset, three single-beat frames
    cfg_mode   = 2'd3;
    cfg_offset = 9'd20;
    beat(32'h00000AFA, 4'hF, 1'b1);
    expect_out("ofs_pos", 32'h14141EFF, 4'hF, 1'b1);
    cfg_offset = 9'h1EC;
    beat(32'hFF151405, 4'hF, 1'b1);
    expect_out("ofs_neg", 32'hEB010000, 4'hF, 1'b1);
    cfg_offset = 9'h0FF;
    beat(32'h00000100, 4'hF, 1'b1);
    expect_out("ofs_max", 32'hFFFFFFFF, 4'hF, 1'b1);
    idle_frame_check("ofs", 3'd4);

    // Threshold at 0x80
    cfg_mode = 2'd2;
    cfg_thr  = 8'h80;
    beat(32'hFF00807F, 4'hF, 1'b1);
    expect_out("thr", 32'hFF00FF00, 4'hF, 1'b1);
    idle_frame_check("thr", 3'd5);

    // Mid-frame mode change from invert to pass lands on the next frame
    cfg_mode = 2'd1;
    beat(32'h01020304, 4'hF, 1'b0);
    expect_out("mf_b1", 32'hFEFDFCFB, 4'hF, 1'b0);
    beat(32'h10203040, 4'hF, 1'b0);
    expect_out("mf_b2", 32'hEFDFCFBF, 4'hF, 1'b0);
    cfg_mode = 2'd0;
    beat(32'h0A0B0C0D, 4'hF, 1'b0);
    expect_out("mf_b3", 32'hF5F4F3F2, 4'hF, 1'b0);
    beat(32'h80FF007F, 4'hF, 1'b0);
    expect_out("mf_b4", 32'h7F00FF80, 4'hF, 1'b0);
    beat(32'h55AA55AA, 4'hF, 1'b1);
    expect_out("mf_b5", 32'hAA55AA55, 4'hF, 1'b1);
    idle_frame_check("mf_f1", 3'd6);
    beat(32'h12345678, 4'hF, 1'b0);
    expect_out("mf_f2_b1", 32'h12345678, 4'hF, 1'b0);
    beat(32'h9ABCDEF0, 4'hF, 1'b1);
    expect_out("mf_f2_b2", 32'h9ABCDEF0, 4'hF, 1'b1);
    idle_frame_check("mf_f2", 3'd7);

    // Backpressure: continuous input, downstream stalled in cycles 3..6
    nb_n       = 0;
    stall_acc  = 0;
    resume_acc = 0;
    emitted    = 0;
    held       = '0;
    for (int c = 0; c < 40; c++) begin
      if (nb_n >= 10 && q.size() == 0) break;
      m_axis_tready = !(c >= 3 && c <= 6);
      s_axis_tvalid = (nb_n < 10);
      s_axis_tdata  = 32'hA5000000 + 32'(nb_n);
      s_axis_tkeep  = 4'hF;
      s_axis_tlast  = (nb_n == 9);
      acc = s_axis_tvalid && s_axis_tready;
      emi = m_axis_tvalid && m_axis_tready;
      if (c == 3) held = m_axis_tdata;
      if (c >= 4 && c <= 6) chk("bp_hold_data", m_axis_tdata, held);
      if (c >= 4 && c <= 7) chk("bp_s_tready_low", 32'(s_axis_tready), 32'd0);
      if (c >= 3 && c <= 6 && acc) stall_acc++;
      if (c >= 8 && c <= 11 && acc) resume_acc++;
      if (emi) begin
        chk("bp_no_extra_beat", 32'(q.size() > 0), 32'd1);
        if (q.size() > 0) begin
          exp_word = q.pop_front();
          chk("bp_order_data", m_axis_tdata, exp_word);
          emitted++;
        end
      end
      if (acc) begin
        q.push_back(s_axis_tdata);
        nb_n++;
      end
      tick();
    end
    s_axis_tvalid = 1'b0;
    m_axis_tready = 1'b1;
    chk("bp_all_sent_and_drained", 32'(nb_n == 10 && q.size() == 0), 32'd1);
    chk("bp_stall_accepts", 32'(stall_acc), 32'd1);
    chk("bp_resume_accepts", 32'(resume_acc), 32'd4);
    chk("bp_emitted", 32'(emitted), 32'd10);
    chk("bp_frame_cnt_wrap", 32'(frame_cnt), 32'd0);

    // Reset while FULL, then new config on the first beat; partial keep
    cfg_mode      = 2'd1;
    m_axis_tready = 1'b0;
    beat(32'h11223344, 4'hF, 1'b0);
    beat(32'h55667788, 4'hF, 1'b0);
    chk("full_s_tready", 32'(s_axis_tready), 32'd0);
    expect_out("full_main", 32'hEEDDCCBB, 4'hF, 1'b0);
    aresetn = 1'b0;
    #1;
    chk("mid_rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
    chk("mid_rst_m_tdata",  m_axis_tdata, 32'h0);
    chk("mid_rst_m_tkeep",  32'(m_axis_tkeep), 32'd0);
    chk("mid_rst_s_tready", 32'(s_axis_tready), 32'd0);
    cfg_mode      = 2'd2;
    cfg_thr       = 8'h10;
    m_axis_tready = 1'b1;
    tick();
    aresetn = 1'b1;
    tick();
    beat(32'h05201030, 4'b0011, 1'b0);
    expect_out("post_rst_keep", 32'h0000FFFF, 4'b0011, 1'b0);
    cfg_mode = 2'd1;
    beat(32'h200F2001, 4'hF, 1'b1);
    expect_out("post_rst_b2", 32'hFF00FF00, 4'hF, 1'b1);
    idle_frame_check("post_rst", 3'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
